// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Walks the board array through every capture for the side to move. Victims
//   come out most-valuable first and, for each victim, aggressors come out
//   least-valuable first. Each capture is emitted as a (from, to) pair on a
//   valid/ready stream.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, abort        begin enumeration (IDLE only) / terminate at once
//   wtm_in              side to move, latched on start
//   busy, done          high outside IDLE / one-cycle pulse on completion
//   move_valid/ready    move stream handshake
//   move_from, move_to  aggressor / victim square
//   move_count          moves emitted since start, saturating at 255
//   board_*             control of the board array and its result
module capture_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       wtm_in,
  output logic       busy,
  output logic       done,
  output logic       move_valid,
  input  logic       move_ready,
  output logic [5:0] move_from,
  output logic [5:0] move_to,
  output logic [7:0] move_count,
  output logic [2:0] board_state_mode,
  output logic [1:0] board_mask_mode,
  output logic       board_wtm,
  output logic [5:0] board_ss1,
  input  logic [6:0] board_data,
  input  logic       board_illegal
);

  localparam logic [2:0] SM_IDLE      = 3'd0;
  localparam logic [2:0] SM_FV        = 3'd1;
  localparam logic [2:0] SM_FA        = 3'd2;
  localparam logic [1:0] MM_NO_CHANGE = 2'd0;
  localparam logic [1:0] MM_EAV_EAA   = 2'd1;
  localparam logic [1:0] MM_DA        = 2'd2;
  localparam logic [1:0] MM_DV_EAA    = 2'd3;

  localparam logic [2:0] LP_SETTLE_LAST = 3'(SETTLE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_FV_WAIT, S_FV_SMP, S_FA_WAIT, S_FA_SMP,
    S_EMIT, S_DIS_AGG, S_DIS_VIC, S_DONE
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [5:0] r_victim, w_victim_nxt;
  logic [5:0] r_aggr, w_aggr_nxt;
  logic [5:0] r_from, w_from_nxt;
  logic [5:0] r_to, w_to_nxt;
  logic       r_valid, w_valid_nxt;
  logic [7:0] r_count, w_count_nxt;
  logic       r_wtm, w_wtm_nxt;
  logic [5:0] r_ss1, w_ss1_nxt;
  logic [2:0] r_sm, w_sm_nxt;
  logic [1:0] r_mm, w_mm_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;

  // Bit 6 of the board result carries no square information.
  logic w_unused_data6;
  assign w_unused_data6 = board_data[6];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_victim <= '0;
      r_aggr   <= '0;
      r_from   <= '0;
      r_to     <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_wtm    <= 1'b0;
      r_ss1    <= '0;
      r_sm     <= SM_IDLE;
      r_mm     <= MM_NO_CHANGE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_victim <= w_victim_nxt;
      r_aggr   <= w_aggr_nxt;
      r_from   <= w_from_nxt;
      r_to     <= w_to_nxt;
      r_valid  <= w_valid_nxt;
      r_count  <= w_count_nxt;
      r_wtm    <= w_wtm_nxt;
      r_ss1    <= w_ss1_nxt;
      r_sm     <= w_sm_nxt;
      r_mm     <= w_mm_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = 3'd0;
    w_victim_nxt = r_victim;
    w_aggr_nxt   = r_aggr;
    w_from_nxt   = r_from;
    w_to_nxt     = r_to;
    w_valid_nxt  = r_valid;
    w_count_nxt  = r_count;
    w_wtm_nxt    = r_wtm;
    w_ss1_nxt    = r_ss1;
    w_sm_nxt     = SM_IDLE;
    w_mm_nxt     = MM_NO_CHANGE;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_CLR;
            w_wtm_nxt   = wtm_in;
            w_count_nxt = '0;
          end
        end
        S_CLR: w_state_nxt = S_FV_WAIT;
        S_FV_WAIT: begin
          if (r_cnt == LP_SETTLE_LAST) w_state_nxt = S_FV_SMP;
          else                         w_cnt_nxt   = r_cnt + 3'd1;
        end
        S_FV_SMP: begin
          if (board_illegal) begin
            w_state_nxt = S_DONE;
          end else begin
            w_victim_nxt = board_data[5:0];
            w_ss1_nxt    = board_data[5:0];
            w_state_nxt  = S_FA_WAIT;
          end
        end
        S_FA_WAIT: begin
          if (r_cnt == LP_SETTLE_LAST) w_state_nxt = S_FA_SMP;
          else                         w_cnt_nxt   = r_cnt + 3'd1;
        end
        S_FA_SMP: begin
          if (board_illegal) begin
            // No aggressor left for this victim: retire the victim.
            w_ss1_nxt   = r_victim;
            w_state_nxt = S_DIS_VIC;
          end else begin
            w_aggr_nxt  = board_data[5:0];
            w_from_nxt  = board_data[5:0];
            w_to_nxt    = r_victim;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_EMIT;
          end
        end
        S_EMIT: begin
          if (move_ready) begin
            w_valid_nxt = 1'b0;
            w_count_nxt = sat_inc(r_count);
            w_ss1_nxt   = r_aggr;
            w_state_nxt = S_DIS_AGG;
          end
        end
        S_DIS_AGG: begin
          // Point the board back at the victim for the next aggressor search.
          w_ss1_nxt   = r_victim;
          w_state_nxt = S_FA_WAIT;
        end
        S_DIS_VIC: w_state_nxt = S_FV_WAIT;
        S_DONE:    w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end

    // Outputs are registered from the state being entered, so they line up
    // with the state they belong to.
    unique case (w_state_nxt)
      S_FV_WAIT, S_FV_SMP: w_sm_nxt = SM_FV;
      S_FA_WAIT, S_FA_SMP: w_sm_nxt = SM_FA;
      default:             w_sm_nxt = SM_IDLE;
    endcase
    unique case (w_state_nxt)
      S_CLR:     w_mm_nxt = MM_EAV_EAA;
      S_DIS_AGG: w_mm_nxt = MM_DA;
      S_DIS_VIC: w_mm_nxt = MM_DV_EAA;
      default:   w_mm_nxt = MM_NO_CHANGE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign move_valid       = r_valid;
  assign move_from        = r_from;
  assign move_to          = r_to;
  assign move_count       = r_count;
  assign board_state_mode = r_sm;
  assign board_mask_mode  = r_mm;
  assign board_wtm        = r_wtm;
  assign board_ss1        = r_ss1;

endmodule

// File: tb/tb_capture_sequencer.sv
// Testbench for capture_sequencer: two instances (SETTLE=1 and SETTLE=3),
// each fed by a scripted board model that reacts to the mask pulses.
module tb_capture_sequencer;

  localparam logic [2:0] SM_IDLE      = 3'd0;
  localparam logic [2:0] SM_FV        = 3'd1;
  localparam logic [2:0] SM_FA        = 3'd2;
  localparam logic [1:0] MM_NO_CHANGE = 2'd0;
  localparam logic [1:0] MM_EAV_EAA   = 2'd1;
  localparam logic [1:0] MM_DA        = 2'd2;
  localparam logic [1:0] MM_DV_EAA    = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance A (SETTLE=1)
  logic       a_start = 1'b0, a_abort = 1'b0, a_wtm_in = 1'b0, a_ready = 1'b0;
  logic       a_busy, a_done, a_valid, a_bwtm, a_bill;
  logic [5:0] a_from, a_to, a_ss1;
  logic [7:0] a_count;
  logic [2:0] a_sm;
  logic [1:0] a_mm;
  logic [6:0] a_bdata;
  int         scn_a = 0, a_vi = 0, a_ai = 0;

  // Instance B (SETTLE=3)
  logic       b_start = 1'b0, b_abort = 1'b0, b_wtm_in = 1'b0, b_ready = 1'b0;
  logic       b_busy, b_done, b_valid, b_bwtm, b_bill;
  logic [5:0] b_from, b_to, b_ss1;
  logic [7:0] b_count;
  logic [2:0] b_sm;
  logic [1:0] b_mm;
  logic [6:0] b_bdata;
  int         scn_b = 0, b_vi = 0, b_ai = 0;

  capture_sequencer #(.SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .wtm_in(a_wtm_in),
    .busy(a_busy), .done(a_done), .move_valid(a_valid), .move_ready(a_ready),
    .move_from(a_from), .move_to(a_to), .move_count(a_count),
    .board_state_mode(a_sm), .board_mask_mode(a_mm), .board_wtm(a_bwtm),
    .board_ss1(a_ss1), .board_data(a_bdata), .board_illegal(a_bill)
  );

  capture_sequencer #(.SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .wtm_in(b_wtm_in),
    .busy(b_busy), .done(b_done), .move_valid(b_valid), .move_ready(b_ready),
    .move_from(b_from), .move_to(b_to), .move_count(b_count),
    .board_state_mode(b_sm), .board_mask_mode(b_mm), .board_wtm(b_bwtm),
    .board_ss1(b_ss1), .board_data(b_bdata), .board_illegal(b_bill)
  );

  // Board model: bit 7 = illegal, bits 6:0 = result. Bit 6 is set on legal
  // results so that only [5:0] may reach the move outputs.
  function automatic logic [7:0] board_resp(input int scn, input logic [2:0] sm,
                                            input int vi, input int ai);
    logic [7:0] r;
    r = 8'h80;
    case (scn)
      0: begin
        if (sm == SM_FV && vi == 0)                r = 8'd64 + 8'd27;
        else if (sm == SM_FA && vi == 0 && ai == 0) r = 8'd64 + 8'd12;
        else if (sm == SM_FA && vi == 0 && ai == 1) r = 8'd64 + 8'd36;
      end
      2: begin
        if (sm == SM_FV && vi == 0)                r = 8'd64 + 8'd19;
        else if (sm == SM_FA && vi == 0 && ai == 0) r = 8'd64 + 8'd8;
      end
      3: begin
        if (vi < 300) begin
          if (sm == SM_FV)                 r = 8'(vi % 64);
          else if (sm == SM_FA && ai == 0) r = 8'((vi + 1) % 64);
        end
      end
      default: r = 8'h80;
    endcase
    return r;
  endfunction

  always_comb {a_bill, a_bdata} = board_resp(scn_a, a_sm, a_vi, a_ai);
  always_comb {b_bill, b_bdata} = board_resp(scn_b, b_sm, b_vi, b_ai);

  always @(posedge clk) begin
    if (a_mm == MM_EAV_EAA)     begin a_vi <= 0; a_ai <= 0; end
    else if (a_mm == MM_DA)       a_ai <= a_ai + 1;
    else if (a_mm == MM_DV_EAA) begin a_vi <= a_vi + 1; a_ai <= 0; end
    if (b_mm == MM_EAV_EAA)     begin b_vi <= 0; b_ai <= 0; end
    else if (b_mm == MM_DA)       b_ai <= b_ai + 1;
    else if (b_mm == MM_DV_EAA) begin b_vi <= b_vi + 1; b_ai <= 0; end
  end

  // Monitors
  int a_done_cnt = 0, b_done_cnt = 0, a_valid_cyc = 0, b_wtm_bad = 0;
  int a_mv_q[$], a_da_q[$], a_dv_q[$], b_mv_q[$], b_runs[$];
  int b_run = 0;
  logic [2:0] b_prev_sm = SM_IDLE;
  logic [5:0] b_prev_ss1 = 6'd0;

  always @(negedge clk) begin
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (a_valid) a_valid_cyc <= a_valid_cyc + 1;
    if (a_valid && a_ready) a_mv_q.push_back(int'(a_from) * 64 + int'(a_to));
    if (a_mm == MM_DA) a_da_q.push_back(int'(a_ss1));
    if (a_mm == MM_DV_EAA) a_dv_q.push_back(int'(a_ss1));
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if (b_valid && b_ready) b_mv_q.push_back(int'(b_from) * 64 + int'(b_to));
    if (b_busy && !b_bwtm) b_wtm_bad <= b_wtm_bad + 1;
    // Length of each stretch where the board is asked a question with
    // unchanged mode and square.
    if (b_sm != SM_IDLE && b_sm == b_prev_sm && b_ss1 == b_prev_ss1) begin
      b_run <= b_run + 1;
    end else begin
      if (b_run > 0) b_runs.push_back(b_run);
      b_run <= (b_sm != SM_IDLE) ? 1 : 0;
    end
    b_prev_sm  <= b_sm;
    b_prev_ss1 <= b_ss1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  // Called right after start_a(); k=1 is the first cycle after start.
  task automatic run_a(input int budget, output int k_done, output int k_valid);
    k_done = -1;
    k_valid = -1;
    for (int k = 1; k <= budget; k++) begin
      if (k_valid < 0 && a_valid) k_valid = k;
      if (a_done) begin
        k_done = k;
        break;
      end
      tick();
    end
    if (k_done < 0) chk("a_done_timeout", 0, 1);
  endtask

  task automatic wait_valid_a(input int budget);
    int ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (a_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (ok == 0) chk("a_valid_timeout", 0, 1);
  endtask

  int kd, kv, base_mv, base_da, base_dv, base_dn, base_vc;

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_from", a_from, 0);
    chk("rst_to", a_to, 0);
    chk("rst_count", a_count, 0);
    chk("rst_sm", a_sm, SM_IDLE);
    chk("rst_mm", a_mm, MM_NO_CHANGE);
    chk("rst_wtm", a_bwtm, 0);
    chk("rst_ss1", a_ss1, 0);
    rst_n = 1'b1;
    tick();

    // Two captures on one victim
    scn_a = 0; a_ready = 1'b1;
    base_mv = a_mv_q.size(); base_da = a_da_q.size(); base_dv = a_dv_q.size();
    base_dn = a_done_cnt;
    start_a();
    chk("t1_clr_mm", a_mm, MM_EAV_EAA);
    chk("t1_clr_busy", a_busy, 1);
    run_a(200, kd, kv);
    chk("t1_first_move_k", kv, 6);
    chk("t1_done_k", kd, 17);
    tick(); tick();
    chk("t1_nmoves", a_mv_q.size() - base_mv, 2);
    chk("t1_move0", a_mv_q[base_mv], 12 * 64 + 27);
    chk("t1_move1", a_mv_q[base_mv + 1], 36 * 64 + 27);
    chk("t1_nda", a_da_q.size() - base_da, 2);
    chk("t1_da0", a_da_q[base_da], 12);
    chk("t1_da1", a_da_q[base_da + 1], 36);
    chk("t1_ndv", a_dv_q.size() - base_dv, 1);
    chk("t1_dv0", a_dv_q[base_dv], 27);
    chk("t1_done_pulses", a_done_cnt - base_dn, 1);
    chk("t1_count", a_count, 2);
    chk("t1_idle_busy", a_busy, 0);

    // No captures at all
    scn_a = 1;
    base_mv = a_mv_q.size(); base_vc = a_valid_cyc; base_dn = a_done_cnt;
    start_a();
    chk("t2_clr_mm", a_mm, MM_EAV_EAA);
    run_a(50, kd, kv);
    chk("t2_done_k", kd, 4);
    tick();
    chk("t2_valid_cycles", a_valid_cyc - base_vc, 0);
    chk("t2_nmoves", a_mv_q.size() - base_mv, 0);
    chk("t2_count", a_count, 0);
    chk("t2_done_pulses", a_done_cnt - base_dn, 1);

    // Consumer stall
    scn_a = 2; a_ready = 1'b0;
    start_a();
    wait_valid_a(50);
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", a_valid, 1);
      chk("t3_from", a_from, 8);
      chk("t3_to", a_to, 19);
      chk("t3_mm", a_mm, MM_NO_CHANGE);
      chk("t3_count", a_count, 0);
      tick();
    end
    a_ready = 1'b1;
    tick();
    chk("t3_valid_after", a_valid, 0);
    chk("t3_count_after", a_count, 1);
    run_a(50, kd, kv);
    tick();
    chk("t3_count_end", a_count, 1);

    // Start with abort in IDLE
    a_start = 1'b1; a_abort = 1'b1;
    tick();
    a_start = 1'b0; a_abort = 1'b0;
    chk("t4_start_abort_busy", a_busy, 0);
    tick();
    chk("t4_start_abort_busy2", a_busy, 0);

    // Abort during EMIT of the second move
    scn_a = 0; a_ready = 1'b0;
    base_dn = a_done_cnt;
    start_a();
    wait_valid_a(50);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    wait_valid_a(50);
    chk("t4_second_from", a_from, 36);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("t4_busy", a_busy, 0);
    chk("t4_valid", a_valid, 0);
    chk("t4_sm", a_sm, SM_IDLE);
    chk("t4_mm", a_mm, MM_NO_CHANGE);
    chk("t4_done", a_done, 0);
    chk("t4_count_kept", a_count, 1);
    repeat (5) tick();
    chk("t4_no_done", a_done_cnt - base_dn, 0);
    a_ready = 1'b1;
    start_a();
    chk("t4_restart_mm", a_mm, MM_EAV_EAA);
    chk("t4_restart_count", a_count, 0);
    run_a(200, kd, kv);
    tick();
    chk("t4_restart_count_end", a_count, 2);
    chk("t4_restart_done", a_done_cnt - base_dn, 1);

    // Reset mid-operation
    scn_a = 2; a_ready = 1'b0;
    start_a();
    wait_valid_a(50);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_valid", a_valid, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_count", a_count, 0);
    chk("t5_ss1", a_ss1, 0);
    chk("t5_sm", a_sm, SM_IDLE);
    tick();

    // SETTLE=3, white to move, start pulses while busy
    scn_b = 0; b_ready = 1'b1; b_wtm_in = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0; b_wtm_in = 1'b0;
    kd = -1;
    for (int k = 1; k <= 200; k++) begin
      if (b_done) begin
        kd = k;
        break;
      end
      b_start = (k >= 2 && k <= 6) ? 1'b1 : 1'b0;
      tick();
      b_start = 1'b0;
    end
    if (kd < 0) chk("b_done_timeout", 0, 1);
    chk("t6_done_k", kd, 27);
    repeat (5) tick();
    chk("t6_busy_after", b_busy, 0);
    chk("t6_done_pulses", b_done_cnt, 1);
    chk("t6_count", b_count, 2);
    chk("t6_nmoves", b_mv_q.size(), 2);
    chk("t6_move0", b_mv_q[0], 12 * 64 + 27);
    chk("t6_move1", b_mv_q[1], 36 * 64 + 27);
    chk("t6_wtm_bad", b_wtm_bad, 0);
    chk("t6_wtm_latched", b_bwtm, 1);
    chk("t6_nruns", b_runs.size(), 5);
    foreach (b_runs[i]) chk("t6_run_len", b_runs[i], 4);

    // 300 captures, counter saturates
    scn_a = 3; a_ready = 1'b1;
    base_mv = a_mv_q.size(); base_dn = a_done_cnt;
    start_a();
    run_a(5000, kd, kv);
    tick();
    chk("t7_nmoves", a_mv_q.size() - base_mv, 300);
    chk("t7_move_first", a_mv_q[base_mv], 1 * 64 + 0);
    chk("t7_move_last", a_mv_q[base_mv + 299], 44 * 64 + 43);
    chk("t7_count_sat", a_count, 255);
    chk("t7_done", a_done_cnt - base_dn, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
